// File: rtl/ifetch_queue_if.sv
// Signal bundle between the fetch queue, the PC register, instruction memory and decode.
// The master modport is the fetch queue's view; slave is the surrounding pipeline and memory.
interface ifetch_queue_if;
    logic        pc;
    logic [31:0] pc_q;
    logic        pc_stall;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  pc_q, redirect, imem_rvalid, imem_rdata, id_stall,
        output pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output pc_q, redirect, imem_rvalid, imem_rdata, id_stall,
        input  pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues one imem read at a time for the current PC and buffers
// returned words with their PC in a small in-order FIFO feeding decode.
module ifetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     req_pc;
    logic [31:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            fifo_valid;
    logic            pop;
    logic            wr;
    logic            issue;
    logic [CW:0]     credit;

    // Issue credit counts the entry a live request will occupy, so a full FIFO is never overwritten.
    always_comb begin
        fifo_valid = (count != '0);
        pop        = fifo_valid & ~bus.id_stall & ~bus.redirect;
        wr         = bus.imem_rvalid & (state == ST_WAIT) & ~bus.redirect;
        credit     = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(state == ST_WAIT);
        issue      = ~rst & ~bus.redirect
                   & ((state == ST_IDLE) | bus.imem_rvalid)
                   & (credit < (CW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A redirect with a request still in flight moves to DROP so its response is discarded.
    always_comb begin
        next_state = state;
        if (bus.redirect) begin
            if (bus.imem_rvalid) begin
                next_state = ST_IDLE;
            end else if (state != ST_IDLE) begin
                next_state = ST_DROP;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        next_state = ST_WAIT;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        next_state = issue ? ST_WAIT : ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.imem_req  = issue;
        bus.imem_addr = bus.pc_q;
        bus.pc_stall  = ~issue & ~bus.redirect;
        bus.if_valid  = fifo_valid;
        bus.if_pc     = fifo_valid ? pc_mem[rd_ptr]    : 32'h0;
        bus.if_instr  = fifo_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            req_pc <= 32'h0;
        end else begin
            if (issue) begin
                req_pc <= bus.pc_q;
            end
            if (bus.redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count + CW'(wr) - CW'(pop);
                if (wr) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: models the PC register and a fixed-latency imem,
// and compares outputs each cycle against hand-derived vector tables.
module tb_ifetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifetch_queue_if bus ();

    ifetch_queue #(
        .DEPTH    (2),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    // stall/redir/tgt drive the cycle; req/addr/pcs/valid/ipc are the expected outputs.
    typedef struct {
        int stall;
        int redir;
        int tgt;
        int req;
        int addr;
        int pcs;
        int valid;
        int ipc;
    } vec_t;

    rsp_t        rsp_q[$];
    int          cyc = 0;
    int          lat = 1;
    logic        pc_adv = 1'b0;
    logic        redir_prev = 1'b0;
    logic [31:0] tgt_prev = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    vec_t t2 [9] = '{
        '{1,0,0, 1,0,  0,0,0},
        '{1,0,0, 1,4,  0,0,0},
        '{1,0,0, 0,0,  1,1,0},
        '{1,0,0, 0,0,  1,1,0},
        '{1,0,0, 0,0,  1,1,0},
        '{0,0,0, 1,8,  0,1,0},
        '{0,0,0, 1,12, 0,1,4},
        '{0,0,0, 1,16, 0,1,8},
        '{0,0,0, 1,20, 0,1,12}
    };

    vec_t t3 [11] = '{
        '{0,0,0, 1,0,  0,0,0},
        '{0,0,0, 0,0,  1,0,0},
        '{0,0,0, 0,0,  1,0,0},
        '{0,0,0, 1,4,  0,0,0},
        '{0,0,0, 0,0,  1,1,0},
        '{0,0,0, 0,0,  1,0,0},
        '{0,0,0, 1,8,  0,0,0},
        '{0,0,0, 0,0,  1,1,4},
        '{0,0,0, 0,0,  1,0,0},
        '{0,0,0, 1,12, 0,0,0},
        '{0,0,0, 0,0,  1,1,8}
    };

    vec_t t4 [14] = '{
        '{0,0,0,      1,0,      0,0,0},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      1,4,      0,0,0},
        '{0,0,0,      0,0,      1,1,0},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      1,8,      0,0,0},
        '{0,1,32'h100,0,0,      0,1,4},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      1,32'h100,0,0,0},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      0,0,      1,0,0},
        '{0,0,0,      1,32'h104,0,0,0},
        '{0,0,0,      0,0,      1,1,32'h100}
    };

    vec_t t5 [7] = '{
        '{0,0,0,      1,0,      0,0,0},
        '{0,0,0,      1,4,      0,0,0},
        '{0,0,0,      1,8,      0,1,0},
        '{0,1,32'h200,0,0,      0,1,4},
        '{0,0,0,      1,32'h200,0,0,0},
        '{0,0,0,      1,32'h204,0,0,0},
        '{0,0,0,      1,32'h208,0,1,32'h200}
    };

    vec_t t6a [5] = '{
        '{0,0,0, 1,0, 0,0,0},
        '{0,0,0, 0,0, 1,0,0},
        '{0,0,0, 0,0, 1,0,0},
        '{0,0,0, 1,4, 0,0,0},
        '{0,0,0, 0,0, 1,1,0}
    };

    vec_t t6b [5] = '{
        '{0,0,0, 1,0, 0,0,0},
        '{0,0,0, 0,0, 1,0,0},
        '{0,0,0, 0,0, 1,0,0},
        '{0,0,0, 1,4, 0,0,0},
        '{0,0,0, 0,0, 1,1,0}
    };

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic resetDut(input int l);
        lat             = l;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.id_stall    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.pc_q        = 32'h0;
        rsp_q.delete();
        pc_adv     = 1'b0;
        redir_prev = 1'b0;
        tgt_prev   = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_valid", 32'(bus.if_valid), 32'h0);
        checkOutput("rst_pc",    bus.if_pc,         32'h0);
        checkOutput("rst_instr", bus.if_instr,      NOP);
        checkOutput("rst_req",   32'(bus.imem_req), 32'h0);
    endtask

    // One clock cycle of the environment: PC register, memory responder, then DUT inputs.
    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] tgt,
                                 input logic rst_val);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            bus.pc_q = 32'h0;
        end else if (redir_prev) begin
            bus.pc_q = tgt_prev;
        end else if (pc_adv) begin
            bus.pc_q = bus.pc_q + 32'd4;
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memWord(rsp_q[0].addr);
            void'(rsp_q.pop_front());
        end
        rst          = rst_val;
        bus.id_stall = stall;
        bus.redirect = redir;
        #1;
        if (bus.imem_req) begin
            rsp_q.push_back('{bus.imem_addr, cyc + lat});
        end
        pc_adv     = ~bus.pc_stall & ~rst;
        redir_prev = redir & ~rst;
        tgt_prev   = tgt;
    endtask

    task automatic runVec(input string tag, input int idx, input vec_t v);
        applyStimulus(v.stall != 0, v.redir != 0, 32'(v.tgt), 1'b0);
        checkOutput($sformatf("%s[%0d].req", tag, idx),   32'(bus.imem_req), 32'(v.req));
        if (v.req != 0) begin
            checkOutput($sformatf("%s[%0d].addr", tag, idx), bus.imem_addr, 32'(v.addr));
        end
        checkOutput($sformatf("%s[%0d].stall", tag, idx), 32'(bus.pc_stall), 32'(v.pcs));
        checkOutput($sformatf("%s[%0d].valid", tag, idx), 32'(bus.if_valid), 32'(v.valid));
        checkOutput($sformatf("%s[%0d].pc", tag, idx),    bus.if_pc,         32'(v.ipc));
        checkOutput($sformatf("%s[%0d].instr", tag, idx), bus.if_instr,
                    (v.valid != 0) ? memWord(32'(v.ipc)) : NOP);
    endtask

    initial begin
        $display("[TB] start");

        // Streaming with single-cycle memory: one instruction per cycle after a two-cycle fill.
        resetDut(1);
        for (int k = 0; k < 8; k++) begin
            vec_t v;
            v = '{0, 0, 0, 1, 4*k, 0, (k >= 2) ? 1 : 0, (k >= 2) ? 4*(k-2) : 0};
            runVec("t1", k, v);
        end

        resetDut(1);
        for (int k = 0; k < 9; k++) runVec("t2", k, t2[k]);

        resetDut(3);
        for (int k = 0; k < 11; k++) runVec("t3", k, t3[k]);

        resetDut(3);
        for (int k = 0; k < 14; k++) runVec("t4", k, t4[k]);

        resetDut(1);
        for (int k = 0; k < 7; k++) runVec("t5", k, t5[k]);

        // Reset lands while the request for 0x4 is outstanding; its late response must be ignored.
        resetDut(3);
        for (int k = 0; k < 5; k++) runVec("t6a", k, t6a[k]);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 32'(bus.if_valid), 32'h0);
        checkOutput("t6_async_pc",    bus.if_pc,         32'h0);
        checkOutput("t6_async_instr", bus.if_instr,      NOP);
        checkOutput("t6_async_req",   32'(bus.imem_req), 32'h0);
        bus.pc_q   = 32'h0;
        pc_adv     = 1'b0;
        redir_prev = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t6_hold_req", 32'(bus.imem_req), 32'h0);
        for (int k = 0; k < 5; k++) runVec("t6b", k, t6b[k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
